// File: rtl/node_input_scheduler.sv
// node_input_scheduler
//   Round-robin scheduler for a node's shared 11-bit ingress path. Requesters
//   0..NREQ-2 are router input ports and NREQ-1 is the local core injection
//   port. The winner's packet goes into a single-entry registered output
//   stage. A credit counter makes the core wait for at least CORE_QUOTA
//   router grants between its own grants while router traffic is pending.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   req_valid   per-requester packet valid
//   req_data    packed packets, requester i at [i*WIDTH +: WIDTH]
//   req_ready   one-hot accept, combinational from arbitration
//   out_valid   registered packet valid toward the processing chain
//   out_data    registered packet
//   out_src     index of the requester that produced out_data
//   out_ready   downstream accept
//   core_block  core request currently masked by the quota
module node_input_scheduler #(
    parameter int NREQ       = 5,
    parameter int WIDTH      = 11,
    parameter int CORE_QUOTA = 3,
    parameter int SRCW       = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRCW-1:0]       out_src,
    input  logic                  out_ready,
    output logic                  core_block
);

    localparam int CW   = $clog2(CORE_QUOTA + 1);
    localparam int CORE = NREQ - 1;

    logic [SRCW-1:0] rr_ptr;
    logic [CW-1:0]   credit;

    logic            load;
    logic            router_pending;
    logic [NREQ-1:0] elig;
    logic            any_elig;
    logic            grant;
    logic            found;
    logic [SRCW-1:0] winner;
    int unsigned     idx;

    // Single-entry pipe: a full register may drain and refill in one cycle.
    assign load           = !out_valid || out_ready;
    assign router_pending = |req_valid[CORE-1:0];

    // Core is only masked while it still owes router grants and a router
    // actually wants the path; alone it is served immediately.
    always_comb begin
        elig       = req_valid;
        elig[CORE] = req_valid[CORE] && ((credit == '0) || !router_pending);
    end

    assign core_block = req_valid[CORE] && !elig[CORE];
    assign any_elig   = |elig;
    assign grant      = load && any_elig && !reset;

    // First eligible index scanning from rr_ptr upward with wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && elig[SRCW'(idx)]) begin
                found  = 1'b1;
                winner = SRCW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
            credit    <= '0;
        end else if (load) begin
            if (any_elig) begin
                out_valid <= 1'b1;
                out_data  <= req_data[int'(winner)*WIDTH +: WIDTH];
                out_src   <= winner;
                rr_ptr    <= (winner == SRCW'(CORE)) ? '0 : winner + 1'b1;
                if (winner == SRCW'(CORE)) begin
                    credit <= CW'(CORE_QUOTA);
                end else if (credit != '0) begin
                    credit <= credit - 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_node_input_scheduler.sv
module tb_node_input_scheduler;

    localparam int NREQ  = 5;
    localparam int WIDTH = 11;
    localparam int SRCW  = 3;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SRCW-1:0]       out_src;
    logic                  out_ready;
    logic                  core_block;

    node_input_scheduler #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .CORE_QUOTA(3),
        .SRCW(SRCW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .out_ready(out_ready),
        .core_block(core_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0]      rd [NREQ];
    logic [SRCW+WIDTH-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input int src);
        exp_q.push_back({SRCW'(src), rd[src]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the current request pattern for k edges, then drain the pipe.
    task automatic run(input int k, input string name);
        repeat (k) tick();
        req_valid = '0;
        tick();
        tick();
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every downstream transfer must match the next
    // expected packet in order.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out got src=%0d data=%h exp=none", out_src, out_data);
            end else begin
                logic [SRCW+WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("out_pkt", {18'd0, out_src, out_data}, {18'd0, e});
            end
        end
    end

    logic cb_exp [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rd[0] = 11'h101;
        rd[1] = 11'h182;
        rd[2] = 11'h203;
        rd[3] = 11'h284;
        rd[4] = 11'h4F2;
        req_data  = {rd[4], rd[3], rd[2], rd[1], rd[0]};
        req_valid = '1;
        out_ready = 1'b1;
        reset     = 1'b1;

        // T1: reset held with everything requesting
        tick();
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_out_valid", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(0); push(1); push(2); push(3); push(4);
        run(5, "t1_queue_empty");

        // T2: routers only, plain round-robin (rr=0, credit=3 at start)
        req_valid = 5'b01111;
        for (int i = 0; i < 8; i++) push(i % 4);
        run(8, "t2_queue_empty");

        // T3a: everyone valid (rr=4, credit=0 at start)
        req_valid = 5'b11111;
        push(4); push(0); push(1); push(2); push(3);
        push(4); push(0); push(1); push(2); push(3);
        run(10, "t3a_queue_empty");

        // T3b: router 0 + core, quota forces three router grants per core grant
        req_valid = 5'b10001;
        push(4); push(0); push(0); push(0); push(4);
        push(0); push(0); push(0); push(4);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("t3_core_block", 32'(core_block), 32'(cb_exp[i]));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        tick();
        tick();
        check("t3b_queue_empty", exp_q.size(), 0);

        // T4: core alone bypasses the quota (credit=3 before the second grant)
        req_valid = 5'b10000;
        push(4); push(4);
        tick();
        @(negedge clk);
        check("t4_core_block", 32'(core_block), 0);
        check("t4_req_ready", 32'(req_ready), 32'h10);
        @(posedge clk);
        #1;
        req_valid = '0;
        tick();
        tick();
        check("t4_queue_empty", exp_q.size(), 0);

        // T5: backpressure, then drain and refill in the same cycle
        push(0); push(1); push(2); push(3);
        out_ready = 1'b0;
        req_valid = 5'b01111;
        tick();
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(out_valid), 1);
            check("t5_hold_src", 32'(out_src), 0);
            check("t5_hold_data", 32'(out_data), 32'(rd[0]));
            check("t5_hold_ready", 32'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_refill_ready", 32'(req_ready), 32'h02);
        @(posedge clk);
        #1;
        tick();
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t5_queue_empty", exp_q.size(), 0);

        // T6: reset while a packet sits in the output register; it is dropped
        push(0);
        req_valid = 5'b01111;
        tick();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(0); push(1); push(2);
        run(3, "t6_queue_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
